mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter attached to the core's memory-stage data port. It decodes `memWriteM`, `ALUResultM` and `writeDataM` alongside `Data_Memory` and queues written bytes in a FIFO. It serialises each byte as 8N1 on `tx` and returns status on a read-data bus, which the top level muxes into `readDataM` when `sel` is high.

---
 rtl/mmio_uart_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Register window: TXDATA (0x0), STATUS (0x4), CTRL (0x8), reserved (0xC).
// Optional feature macro: UART_TX_IRQ_EN adds CTRL[0] (irq enable) and the irq port.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] writeDataM,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_t;

    state_t            state;
    reg_t              offset;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [7:0]        shift_reg;
    logic [2:0]        bit_cnt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [31:0]       status_word;
    logic [31:0]       ctrl_word;

    logic wr_en;
    logic push_req;
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic baud_done;
    logic [7:0] head;

    // Address bits below word granularity and store data above the byte lane
    // carry no meaning in this window.
    logic unused_bits;
    assign unused_bits = ^{ALUResultM[1:0], writeDataM[31:8]};

    assign sel       = (ALUResultM[31:4] == BASE_ADDR[31:4]);
    assign offset    = reg_t'(ALUResultM[3:2]);
    assign wr_en     = sel & memWriteM;
    assign push_req  = wr_en & (offset == REG_TXDATA);
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    // A push into a full FIFO is dropped even when the FSM pops on the same edge.
    assign push      = push_req & ~full;
    assign baud_done = (baud_cnt == BAUD_LAST);
    // The FSM takes the head either from IDLE or at the last cycle of a stop bit.
    assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & baud_done));
    assign head      = fifo_mem[rd_ptr];

    // FIFO storage: write-only on accepted pushes.
    // NOTE: the storage array has no reset; pointers and count decide which entries
    // are valid, so clearing them is enough to empty the FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= writeDataM[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    // NOTE: sequential state uses non-blocking assignments so every register in
    // the design samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (wr_en && (offset == REG_STATUS) && writeDataM[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM; tx is registered from the current state, so the line lags
    // the state by one cycle while every level still lasts CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (!empty) begin
                        shift_reg <= head;
                        bit_cnt   <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= shift_reg[0];
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (!empty) begin
                            shift_reg <= head;
                            bit_cnt   <= '0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en;

    // CTRL register and the registered "drained and idle" interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_en && (offset == REG_CTRL)) begin
                irq_en <= writeDataM[0];
            end
            irq <= irq_en & empty & (state == IDLE);
        end
    end

    assign ctrl_word = {31'b0, irq_en};
`else
    assign ctrl_word = '0;
`endif

    // STATUS is assembled from registered state only, so a read in the cycle of
    // a push still shows the pre-push occupancy.
    // NOTE: every output of an always_comb gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        status_word            = '0;
        status_word[0]         = (state != IDLE);
        status_word[1]         = full;
        status_word[2]         = empty;
        status_word[3]         = overflow;
        status_word[8 +: CNT_W] = count;
    end

    // Zero-wait-state read mux; TXDATA and the reserved slot read as zero.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (offset)
                REG_STATUS: rdata = status_word;
                REG_CTRL:   rdata = ctrl_word;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: directed register accesses, with every accepted
// byte expanded into per-cycle expected tx levels that a monitor pops and compares.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        memWriteM  = 1'b0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] writeDataM = '0;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;
`ifdef UART_TX_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL_EXP = 32'h1;
`else
    localparam logic [31:0] CTRL_EXP = 32'h0;
`endif

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   push_cyc = 0;
    bit   mon_en   = 1'b0;
    bit   active   = 1'b0;
    logic lvl;
    logic exp_q[$];

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memWriteM  (memWriteM),
        .ALUResultM (ALUResultM),
        .writeDataM (writeDataM),
        .sel        (sel),
        .rdata      (rdata),
        .tx         (tx)
`ifdef UART_TX_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expd);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        ALUResultM = addr;
        memWriteM  = 1'b0;
        #1;
        data = rdata;
    endtask

    // Start bit, eight data bits LSB first, stop bit; each level CPB cycles.
    task automatic push_frame(input logic [7:0] b);
        for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < CPB; k++) exp_q.push_back(b[i]);
        end
        for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
    endtask

    // One store cycle; accepted bytes go to the scoreboard after the edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input bit accept);
        ALUResultM = addr;
        writeDataM = data;
        memWriteM  = 1'b1;
        @(posedge clk);
        #1;
        memWriteM = 1'b0;
        if (accept) begin
            if (exp_q.size() == 0 && !active) push_cyc = cyc;
            push_frame(data[7:0]);
        end
    endtask

    // tx monitor: idle-high when nothing is queued, otherwise the exact level per cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!active && exp_q.size() != 0 && tx === 1'b0) begin
                check("start_latency", 32'(cyc - push_cyc), 32'd2);
                active = 1'b1;
            end
            if (active) begin
                lvl = exp_q.pop_front();
                check("tx_level", 32'(tx), 32'(lvl));
                if (exp_q.size() == 0) active = 1'b0;
            end else if (exp_q.size() == 0) begin
                check("idle_tx", 32'(tx), 32'd1);
            end
        end
    end

    initial begin
        logic [31:0] r;

        // Reset sequence
        reset = 1'b1;
        step(2);
        check("reset_tx", 32'(tx), 32'd1);
        reset = 1'b0;
        rd(BASE + 32'h4, r);
        check("reset_status", r, 32'h0000_0004);
        rd(BASE, r);
        check("txdata_read", r, 32'h0);
        rd(BASE + 32'h8, r);
        check("ctrl_reset", r, 32'h0);
        mon_en = 1'b1;

        // Decode isolation
        step();
        ALUResultM = 32'h0000_2000;
        #1 check("sel_outside", 32'(sel), 32'd0);
        check("rdata_outside", rdata, 32'h0);
        ALUResultM = BASE + 32'hC;
        #1 check("sel_rsvd", 32'(sel), 32'd1);
        check("rsvd_read", rdata, 32'h0);
        ALUResultM = BASE + 32'h10;
        #1 check("sel_above", 32'(sel), 32'd0);
        ALUResultM = BASE - 32'h4;
        #1 check("sel_below", 32'(sel), 32'd0);
        wr(32'h0000_2000, 32'h41, 1'b0);
        wr(BASE + 32'hC, 32'h42, 1'b0);
        step(3);
        rd(BASE + 32'h4, r);
        check("isolation_status", r, 32'h0000_0004);

        // Single byte
        step(2);
        wr(BASE, 32'h55, 1'b1);
        step(39);
        rd(BASE + 32'h4, r);
        check("single_busy_in_stop", r, 32'h0000_0005);
        step(2);
        rd(BASE + 32'h4, r);
        check("single_done_status", r, 32'h0000_0004);

        // Back-to-back frames
        step(3);
        wr(BASE, 32'hA5, 1'b1);
        wr(BASE, 32'h3C, 1'b1);
        for (int i = 0; i < 80; i++) begin
            rd(BASE + 32'h4, r);
            check("b2b_busy", 32'(r[0]), 32'd1);
            step();
        end
        rd(BASE + 32'h4, r);
        check("b2b_idle", r, 32'h0000_0004);

        // Overflow: first five accepted, sixth dropped
        step(3);
        for (int i = 0; i < 6; i++) begin
            wr(BASE, 32'h10 + 32'(i), (i < 5));
        end
        rd(BASE + 32'h4, r);
        check("ovf_status", r, 32'h0000_040B);
        wr(BASE + 32'h4, 32'h8, 1'b0);
        rd(BASE + 32'h4, r);
        check("ovf_cleared", r, 32'h0000_0403);
        step(200);
        rd(BASE + 32'h4, r);
        check("ovf_drained", r, 32'h0000_0004);

        // Reset mid-frame with two bytes still queued
        step(3);
        wr(BASE, 32'h11, 1'b1);
        wr(BASE, 32'h22, 1'b1);
        wr(BASE, 32'h33, 1'b1);
        step(8);
        rd(BASE + 32'h4, r);
        check("midframe_status", r, 32'h0000_0201);
        reset  = 1'b1;
        mon_en = 1'b0;
        exp_q.delete();
        active = 1'b0;
        step();
        check("midframe_tx", 32'(tx), 32'd1);
        rd(BASE + 32'h4, r);
        check("midframe_flushed", r, 32'h0000_0004);
        reset = 1'b0;
        step();
        mon_en = 1'b1;
        step(100);
        rd(BASE + 32'h4, r);
        check("post_reset_status", r, 32'h0000_0004);

        // CTRL: read/write with the irq build, inert otherwise
        wr(BASE + 32'h8, 32'h1, 1'b0);
        rd(BASE + 32'h8, r);
        check("ctrl_readback", r, CTRL_EXP);
`ifdef UART_TX_IRQ_EN
        step();
        check("irq_enabled", 32'(irq), 32'd1);
        wr(BASE, 32'h0F, 1'b1);
        step();
        check("irq_after_push", 32'(irq), 32'd0);
        step(40);
        check("irq_before_idle", 32'(irq), 32'd0);
        step();
        check("irq_after_idle", 32'(irq), 32'd1);
`endif
        step(50);
        rd(BASE + 32'h4, r);
        check("final_status", r, 32'h0000_0004);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
